// File: rtl/cp0_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cp0_irq_ctrl_pkg
//   Shared definitions for the CP0 interrupt/exception controller:
//   CP0 register numbers, SR bit positions, exception codes and a small
//   fixed-priority encoder helper.
// ---------------------------------------------------------------------------
package cp0_irq_ctrl_pkg;

  // CP0 register numbers as seen by MTC0/MFC0
  typedef enum logic [4:0] {
    CP0_SR    = 5'd12,
    CP0_CAUSE = 5'd13,
    CP0_EPC   = 5'd14,
    CP0_PRID  = 5'd15
  } cp0_reg_e;

  // Status register bit positions
  localparam int unsigned SR_IE  = 0;
  localparam int unsigned SR_EXL = 1;

  // Cause.ExcCode value for an external interrupt
  localparam logic [4:0] EXC_INT = 5'd0;

  // Index of the highest set bit (higher index wins); 0 when none set.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cp0_irq_ctrl_sync_detect.sv
// ---------------------------------------------------------------------------
// irq_sync_detect
//   Per-line interrupt front end: two-flop synchroniser (s1, s2), a prev
//   flop (s3) for rising-edge detection, and the pending latch.
//   Level lines: pending follows s2 every cycle.
//   Edge lines : pending set on s2 & ~s3, cleared by i_clr (W1C); a new
//                edge in the same cycle as a clear keeps the bit set.
//
// Ports
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_irq      asynchronous interrupt lines
//   i_clr      write-1-to-clear strobe per line (ignored for level lines)
//   o_pending  pending vector
// ---------------------------------------------------------------------------
module irq_sync_detect
  import cp0_irq_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_IRQ   = 6,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_clr,
  output logic [NUM_IRQ-1:0] o_pending
);

  logic [NUM_IRQ-1:0] r_s1;
  logic [NUM_IRQ-1:0] r_s2;
  logic [NUM_IRQ-1:0] r_s3;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pend_nxt;

  assign w_rise = r_s2 & ~r_s3;

  // Edge lines hold until cleared, set dominating clear; level lines track s2.
  assign w_pend_nxt = (EDGE_MASK & (w_rise | (r_pend & ~i_clr)))
                    | (~EDGE_MASK & r_s2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_pend <= '0;
    end else begin
      r_s1   <= i_irq;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_pend_nxt;
    end
  end

  assign o_pending = r_pend;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_irq_ctrl
//   Coprocessor-0 interrupt/exception controller for the 5-stage pipeline.
//   Holds SR, Cause, EPC and PRId; raises int_req when an enabled pending
//   line can be accepted on a real, unstalled ID instruction.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   hw_int          asynchronous device interrupt lines
//   id_pcp1         PC+1 (word address) of the instruction in ID
//   id_valid        ID holds a real instruction
//   pipeline_stall  hazard stall this cycle
//   eret            ERET decoded in ID
//   mtc0_we/sel/wdata  CP0 write port (EX)
//   mfc0_sel/rdata     CP0 read port (combinational)
//   epc             EPC[31:2], the ERET target
//   int_req         take interrupt this cycle (combinational)
//   irq_id          highest-priority enabled pending line
// ---------------------------------------------------------------------------
module cp0_irq_ctrl
  import cp0_irq_ctrl_pkg::*;
#(
  parameter int unsigned        NUM_IRQ   = 6,
  parameter int unsigned        IRQ_BASE  = 10,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter logic [31:0]        PRID      = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] hw_int,
  input  logic [29:0]        id_pcp1,
  input  logic               id_valid,
  input  logic               pipeline_stall,
  input  logic               eret,
  input  logic               mtc0_we,
  input  logic [4:0]         mtc0_sel,
  input  logic [31:0]        mtc0_wdata,
  input  logic [4:0]         mfc0_sel,
  output logic [31:0]        mfc0_rdata,
  output logic [29:0]        epc,
  output logic               int_req,
  output logic [2:0]         irq_id
);

  logic               r_sr_ie;
  logic               r_sr_exl;
  logic [NUM_IRQ-1:0] r_sr_im;
  logic [29:0]        r_epc;

  logic               w_wr_sr;
  logic               w_wr_cause;
  logic               w_wr_epc;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_enabled;
  logic               w_int_req;

  assign w_wr_sr    = mtc0_we && (mtc0_sel == CP0_SR);
  assign w_wr_cause = mtc0_we && (mtc0_sel == CP0_CAUSE);
  assign w_wr_epc   = mtc0_we && (mtc0_sel == CP0_EPC);

  // Only edge bits are W1C; level bits are read-only.
  assign w_clr = w_wr_cause ? (mtc0_wdata[IRQ_BASE +: NUM_IRQ] & EDGE_MASK) : '0;

  irq_sync_detect #(
    .NUM_IRQ   (NUM_IRQ),
    .EDGE_MASK (EDGE_MASK)
  ) u_sync_detect (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_irq     (hw_int),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

  assign w_enabled = w_pending & r_sr_im;

  // Never accepted on a bubble or while stalled; simply retried later.
  assign w_int_req = (|w_enabled) && r_sr_ie && !r_sr_exl
                  && id_valid && !pipeline_stall;

  // Later assignments override: MTC0 SR, then ERET, then the interrupt,
  // so a colliding interrupt owns EXL/EPC while IE/IM still take the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr_ie  <= 1'b0;
      r_sr_exl <= 1'b0;
      r_sr_im  <= '0;
      r_epc    <= '0;
    end else begin
      if (w_wr_sr) begin
        r_sr_ie  <= mtc0_wdata[SR_IE];
        r_sr_exl <= mtc0_wdata[SR_EXL];
        r_sr_im  <= mtc0_wdata[IRQ_BASE +: NUM_IRQ];
      end
      if (eret) begin
        r_sr_exl <= 1'b0;
      end
      if (w_int_req) begin
        r_sr_exl <= 1'b1;
        r_epc    <= 30'(id_pcp1 - 30'd1);
      end else if (w_wr_epc) begin
        r_epc    <= mtc0_wdata[31:2];
      end
    end
  end

  // Cause.ExcCode only ever holds EXC_INT, so it is not stored.
  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_sel)
      CP0_SR: begin
        mfc0_rdata[IRQ_BASE +: NUM_IRQ] = r_sr_im;
        mfc0_rdata[SR_EXL]              = r_sr_exl;
        mfc0_rdata[SR_IE]               = r_sr_ie;
      end
      CP0_CAUSE: begin
        mfc0_rdata[IRQ_BASE +: NUM_IRQ] = w_pending;
        mfc0_rdata[6:2]                 = EXC_INT;
      end
      CP0_EPC:  mfc0_rdata = {r_epc, 2'b00};
      CP0_PRID: mfc0_rdata = PRID;
      default:  mfc0_rdata = '0;
    endcase
  end

  assign int_req = w_int_req;
  assign irq_id  = prio_enc(8'(w_enabled));
  assign epc     = r_epc;

endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
- Parametrised coprocessor-0 interrupt/exception controller for the 5-stage MIPS pipeline.
- Supersedes the fixed 6-line CP0 with:
  - NUM_IRQ hardware lines
  - per-line edge/level mode
  - write-1-to-clear edge pending bits
  - a priority-encoded interrupt ID
  - stall-aware interrupt acceptance
- Connects to the ID stage (PC capture, ERET/EPC redirect), the EX stage (MTC0/MFC0) and the controller (int_req drives the flush).

Parameters:
- NUM_IRQ, 6, number of hardware interrupt lines (1..8).
- IRQ_BASE, 10, bit position of line 0 in SR.IM and Cause.IP. Constraint: IRQ_BASE+NUM_IRQ<=16.
- EDGE_MASK, 0, NUM_IRQ-bit vector; bit i=1 makes line i rising-edge sensitive, otherwise level.
- PRID, 32'h0000_0001, constant returned by PRId (reg 15).

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- hw_int  in  NUM_IRQ  asynchronous device interrupt lines.
- id_pcp1  in  30  word address PC+1 of the instruction currently in ID (bits 31:2).
- id_valid  in  1  ID holds a real instruction, not a bubble.
- pipeline_stall  in  1  hazard stall active this cycle.
- eret  in  1  ERET decoded in ID this cycle.
- mtc0_we  in  1  CP0 write strobe from EX.
- mtc0_sel  in  5  CP0 register number for write.
- mtc0_wdata  in  32  write data.
- mfc0_sel  in  5  CP0 register number for read.
- mfc0_rdata  out  32  read data (combinational).
- epc  out  30  current EPC[31:2], the ERET target.
- int_req  out  1  take interrupt this cycle (combinational).
- irq_id  out  3  index of the highest-priority enabled pending line.

Behaviour:
- Registers:
  - SR(12): IM at [IRQ_BASE+NUM_IRQ-1:IRQ_BASE], EXL bit1, IE bit0; all other bits read 0.
  - Cause(13): IP at the same positions, ExcCode [6:2] (always 0 = Int).
  - EPC(14): bits [31:2]; [1:0] read 0.
  - PRId(15) = PRID.
  - Any other sel reads 0.
- Reset (rst=1 at clock edge): SR=0, Cause=0, EPC=0, sync/prev samplers=0, pending=0. Consequently int_req=0, irq_id=0, epc=0.
- Input sampling: hw_int passes through a 2-flop synchroniser (s1, s2) plus a prev flop (s3).
  - Level line i: pending[i] <= s2[i] every cycle.
  - Edge line i: pending[i] set when s2[i]&~s3[i]; cleared by MTC0 Cause writing 1 at IP bit i; set wins over clear in the same cycle.
  - Latency: a level line asserted at edge N is visible in pending after edge N+3.
- Cause.IP mirrors pending. MTC0 to Cause affects only the W1C edge bits; level bits are read-only.
- enabled = pending & SR.IM.
- int_req = |enabled & SR.IE & ~SR.EXL & id_valid & ~pipeline_stall. No interrupt is accepted on a bubble or during a stall; it is retried on the next eligible cycle.
- irq_id = highest set index of enabled (fixed priority, higher index wins); 0 when none.
- On a clock edge with int_req=1:
  - EPC <= id_pcp1 - 1, the PC of the flushed ID instruction, which is re-executed after ERET.
  - SR.EXL <= 1.
  - Cause.ExcCode <= 0.
- ERET: SR.EXL <= 0 at the clock edge. The epc output is stable in the ERET cycle for the ID redirect.
  - int_req cannot coincide with ERET: EXL is still 1.
  - After ERET, an interrupt may be taken from the following cycle.
- MTC0 SR/EPC: written at the clock edge; visible to mfc0 and to int_req from the next cycle. No same-cycle bypass inside the block; EX forwarding handles it.
- Simultaneous MTC0 and int_req: the interrupt wins for SR.EXL and EPC. All other SR fields (IE, IM) take mtc0_wdata.
- Reset mid-operation: all state is discarded, including pending edges and an in-flight EXL; no interrupt is taken until SR is reprogrammed.

Decomposition:
- Shared package:
  - CP0 register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - SR bit indices: IE=0, EXL=1.
  - EXC_INT=5'd0.
- One sub-module: irq_sync_detect. It holds the per-line synchroniser, edge detect and pending latch, parametrised by NUM_IRQ and EDGE_MASK, and outputs pending.

Test Plan:
- Reset: rst=1 for 2 cycles with hw_int=6'h3F → int_req=0, mfc0 reads of sel 12/13/14 = 0, sel 15 = 0x00000001.
- Level interrupt:
  - Stimulus: SR=0x00000401 (IM0, IE), hw_int[0]=1, id_valid=1, id_pcp1=30'h0C01.
  - Response: int_req=1 exactly 3 cycles later, irq_id=0; next cycle EPC=30'h0C00 (0x00003000), SR.EXL=1, int_req=0.
- Stall/bubble gating: same setup with pipeline_stall=1 for 4 cycles, then id_valid=0 for 1 cycle → int_req stays 0; it asserts on the first cycle with stall=0 and id_valid=1.
- Edge line + W1C (EDGE_MASK=6'b000100):
  - 1-cycle pulse on hw_int[2] → Cause.IP bit12 set and held.
  - MTC0 Cause=0x1000 clears it.
  - A pulse arriving in the same cycle as the clear keeps it set.
- Priority and ERET:
  - Lines 1 and 4 both pending, IM=all → irq_id=4.
  - After the interrupt, ERET → epc output equals the captured EPC, and EXL=0 next cycle.
  - With line 4 still level-high, int_req re-asserts the following cycle.
- MTC0 collision: MTC0 SR=0x00000000 in the same cycle int_req=1 → SR.EXL=1, IE=0, IM=0, and EPC is captured.
